// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register indices, exception vector, ExcCodes, Status shift.
package cp0_regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] CP0_COUNT   = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_COMPARE = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_STATUS  = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE   = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC     = 5'd14;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0004;

  localparam logic [EXC_W-1:0] INT     = 5'd0;
  localparam logic [EXC_W-1:0] SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] BREAK   = 5'd9;
  localparam logic [EXC_W-1:0] TEQ     = 5'd13;

  localparam int unsigned STATUS_SHIFT = 5;

  // Assemble the architectural Cause word from its two live fields.
  function automatic logic [XLEN-1:0] cause_word(input logic ip, input logic [EXC_W-1:0] code);
    cause_word = {16'h0000, ip, 8'h00, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 pipeline-facing bus: control strobes and data in, register views out.
interface cp0_if;
  import cp0_regfile_pkg::*;

  logic              stall;
  logic              mfc0;
  logic              mtc0;
  logic              eret;
  logic              exception;
  logic [ADDR_W-1:0] cp0_addr;
  logic [EXC_W-1:0]  cause;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic [XLEN-1:0]   status;
  logic [XLEN-1:0]   epc_out;
  logic [XLEN-1:0]   exc_addr;
  logic              irq;

  modport master (
    output stall, mfc0, mtc0, eret, exception, cp0_addr, cause, pc, wdata,
    input  rdata, status, epc_out, exc_addr, irq
  );

  modport slave (
    input  stall, mfc0, mtc0, eret, exception, cp0_addr, cause, pc, wdata,
    output rdata, status, epc_out, exc_addr, irq
  );
endinterface

// File: rtl/cp0_regfile_timer.sv
// Free-running Count, Compare register and the sticky timer-pending bit (Cause[15]).
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            count_we_i,
  input  logic            compare_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] count_o,
  output logic [XLEN-1:0] compare_o,
  output logic            timer_ip_o
);

  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic            ip_q, ip_d;

  // Next-state: Count ticks unless overwritten; a Compare write re-arms the pending bit.
  always_comb begin
    count_d   = count_q + XLEN'(1);
    compare_d = compare_q;
    ip_d      = ip_q;
    if (count_we_i) count_d = wdata_i;
    if ((count_q == compare_q) && (compare_q != '0)) ip_d = 1'b1;
    if (compare_we_i) begin
      compare_d = wdata_i;
      ip_d      = 1'b0;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ip_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ip_q      <= ip_d;
    end
  end

  assign count_o    = count_q;
  assign compare_o  = compare_q;
  assign timer_ip_o = ip_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC with exception entry/return, plus the timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  cp0_if.slave bus
);

  logic [XLEN-1:0]  status_q, status_d;
  logic [EXC_W-1:0] exc_q, exc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  count, compare;
  logic             timer_ip;
  logic             wr_en;

  assign wr_en = bus.mtc0 & ~bus.stall;

  // Count/Compare writes are not part of the Status/Cause/EPC priority chain.
  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_we_i   (wr_en && (bus.cp0_addr == CP0_COUNT)),
    .compare_we_i (wr_en && (bus.cp0_addr == CP0_COMPARE)),
    .wdata_i      (bus.wdata),
    .count_o      (count),
    .compare_o    (compare),
    .timer_ip_o   (timer_ip)
  );

  // Next-state: exception > eret > mtc0; stall freezes everything here.
  always_comb begin
    status_d = status_q;
    exc_d    = exc_q;
    epc_d    = epc_q;
    if (!bus.stall) begin
      if (bus.exception) begin
        status_d = status_q << STATUS_SHIFT;
        exc_d    = bus.cause;
        epc_d    = bus.pc;
      end else if (bus.eret) begin
        status_d = status_q >> STATUS_SHIFT;
      end else if (bus.mtc0) begin
        case (bus.cp0_addr)
          CP0_STATUS: status_d = bus.wdata;
          CP0_CAUSE:  exc_d    = bus.wdata[6:2];
          CP0_EPC:    epc_d    = bus.wdata;
          default:    ;
        endcase
      end
    end
  end

  // Architectural Status/Cause/EPC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      exc_q    <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      exc_q    <= exc_d;
      epc_q    <= epc_d;
    end
  end

  // mfc0 read mux; reads pre-edge state so same-cycle mtc0 returns the old value.
  always_comb begin
    bus.rdata = '0;
    if (bus.mfc0) begin
      case (bus.cp0_addr)
        CP0_COUNT:   bus.rdata = count;
        CP0_COMPARE: bus.rdata = compare;
        CP0_STATUS:  bus.rdata = status_q;
        CP0_CAUSE:   bus.rdata = cause_word(timer_ip, exc_q);
        CP0_EPC:     bus.rdata = epc_q;
        default:     bus.rdata = '0;
      endcase
    end
  end

  assign bus.status   = status_q;
  assign bus.epc_out  = epc_q;
  assign bus.exc_addr = bus.eret ? epc_q : EXC_VECTOR;
  assign bus.irq      = status_q[0] & status_q[4] & timer_ip;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed + randomized bench for cp0_regfile against a register-level reference model.
module tb_cp0_regfile;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cp0_if bus ();

  cp0_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] m_count, m_compare, m_status, m_epc;
  logic [4:0]  m_exc;
  logic        m_ip;
  logic [31:0] last_rd, last_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 0; m_epc = 0; m_exc = 0; m_ip = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return (32'(m_ip) * 32'h8000) + (32'(m_exc) * 4);
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // One cycle of the architectural rules, evaluated from the pre-edge state.
  task automatic model_edge(input bit st, mt, er, ex, input logic [4:0] a, c,
                            input logic [31:0] p, w);
    logic [31:0] n_count, n_compare, n_status, n_epc;
    logic [4:0]  n_exc;
    logic        n_ip;
    bit          wr;
    wr        = mt && !st;
    n_count   = m_count + 1;
    n_compare = m_compare;
    n_status  = m_status;
    n_epc     = m_epc;
    n_exc     = m_exc;
    n_ip      = m_ip || (m_count == m_compare && m_compare != 0);
    if (wr && a == 5'd9) n_count = w;
    if (wr && a == 5'd11) begin
      n_compare = w;
      n_ip      = 1'b0;
    end
    if (!st) begin
      if (ex) begin
        n_status = m_status * 32;
        n_exc    = c;
        n_epc    = p;
      end else if (er) begin
        n_status = m_status / 32;
      end else if (wr) begin
        if (a == 5'd12) n_status = w;
        if (a == 5'd13) n_exc = 5'((w / 4) % 32);
        if (a == 5'd14) n_epc = w;
      end
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_epc = n_epc; m_exc = n_exc; m_ip = n_ip;
  endtask

  // Drive one cycle from a negedge, check combinational outputs, clock, check registers.
  task automatic step(input bit st, mf, mt, er, ex, input logic [4:0] a, c,
                      input logic [31:0] p, w);
    bus.stall = st; bus.mfc0 = mf; bus.mtc0 = mt; bus.eret = er; bus.exception = ex;
    bus.cp0_addr = a; bus.cause = c; bus.pc = p; bus.wdata = w;
    #1;
    last_rd  = bus.rdata;
    last_exc = bus.exc_addr;
    chk("rdata", bus.rdata, mf ? model_read(a) : 32'h0);
    chk("exc_addr", bus.exc_addr, er ? m_epc : 32'h4);
    @(posedge clk);
    model_edge(st, mt, er, ex, a, c, p, w);
    #1;
    chk("status", bus.status, m_status);
    chk("epc_out", bus.epc_out, m_epc);
    chk("irq", {31'h0, bus.irq}, {31'h0, m_status[0] & m_status[4] & m_ip});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a);
    step(0, 1, 0, 0, 0, a, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] w);
    step(0, 0, 1, 0, 0, a, 5'd0, 32'h0, w);
  endtask

  initial begin
    logic [4:0]  addrs [5];
    logic [4:0]  ra;
    logic [31:0] rw;
    bit rst_, rmf, rmt, rer, rex;
    addrs[0] = 5'd9; addrs[1] = 5'd11; addrs[2] = 5'd12; addrs[3] = 5'd13; addrs[4] = 5'd14;
    checks = 0; errors = 0;
    bus.stall = 0; bus.mfc0 = 0; bus.mtc0 = 0; bus.eret = 0; bus.exception = 0;
    bus.cp0_addr = 0; bus.cause = 0; bus.pc = 0; bus.wdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_status", bus.status, 32'h0);
    chk("rst_epc", bus.epc_out, 32'h0);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);
    chk("rst_exc_addr", bus.exc_addr, 32'h4);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Count starts at 0 and advances on the first post-reset edge
    rd(5'd9);  chk("count0", last_rd, 32'h0);
    rd(5'd9);  chk("count1", last_rd, 32'h1);
    rd(5'd3);  chk("unmapped", last_rd, 32'h0);

    // Syscall entry and return
    wr(5'd12, 32'h0000_000F);
    step(0, 0, 0, 0, 1, 5'd0, 5'd8, 32'h0040_0010, 32'h0);
    chk("sys_exc_addr", last_exc, 32'h4);
    chk("sys_status", bus.status, 32'h0000_01E0);
    chk("sys_epc", bus.epc_out, 32'h0040_0010);
    rd(5'd13); chk("sys_cause", last_rd, 32'h0000_0020);
    step(0, 0, 0, 1, 0, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("eret_exc_addr", last_exc, 32'h0040_0010);
    chk("eret_status", bus.status, 32'h0000_000F);
    chk("eret_epc", bus.epc_out, 32'h0040_0010);

    // Same-cycle mfc0/mtc0 to one index returns the old value
    step(0, 1, 1, 0, 0, 5'd14, 5'd0, 32'h0, 32'hCAFE_0000);
    chk("old_value", last_rd, 32'h0040_0010);
    chk("new_epc", bus.epc_out, 32'hCAFE_0000);

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9); chk("wrap_pre", last_rd, 32'hFFFF_FFFF);
    rd(5'd9); chk("wrap_post", last_rd, 32'h0);

    // Timer interrupt
    wr(5'd9, 32'h0);
    wr(5'd11, 32'd20);
    wr(5'd12, 32'h11);
    for (int i = 0; i < 60 && !bus.irq; i++) idle();
    chk("irq_rise", {31'h0, bus.irq}, 32'h1);
    rd(5'd9);  chk("irq_count", last_rd, 32'd21);
    rd(5'd13); chk("irq_cause15", last_rd & 32'h8000, 32'h8000);
    wr(5'd11, 32'h0);
    chk("irq_clear", {31'h0, bus.irq}, 32'h0);

    // Stall freezes Status/Cause/EPC but not Count
    rd(5'd9); rw = last_rd;
    step(1, 1, 1, 0, 1, 5'd9, 5'd9, 32'h1234_5678, 32'hDEAD_BEEF);
    chk("stall_status", bus.status, 32'h11);
    chk("stall_epc", bus.epc_out, 32'hCAFE_0000);
    rd(5'd9); chk("stall_count", last_rd, rw + 32'd2);

    // Exception beats mtc0 Status in the same cycle
    step(0, 0, 1, 0, 1, 5'd12, 5'd13, 32'h0000_0100, 32'h0000_FFFF);
    chk("coll_status", bus.status, 32'h0000_0220);
    chk("coll_epc", bus.epc_out, 32'h0000_0100);
    rd(5'd13); chk("coll_cause", last_rd, 32'h0000_0034);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_ = ($urandom_range(0, 3) == 0);
      rmf  = $urandom_range(0, 1) == 1;
      rmt  = $urandom_range(0, 2) == 0;
      rex  = $urandom_range(0, 7) == 0;
      rer  = $urandom_range(0, 7) == 0;
      ra   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                         : addrs[$urandom_range(0, 4)];
      if ((rex || rer) && rmt) ra = addrs[$urandom_range(2, 4)];
      rw = $urandom;
      if (ra == 5'd11 && $urandom_range(0, 1) == 1) rw = m_count + 32'($urandom_range(2, 30));
      if (ra == 5'd12 && $urandom_range(0, 1) == 1) rw = rw & 32'h0000_FFFF;
      step(rst_, rmf, rmt, rer, rex, ra, 5'($urandom_range(0, 31)), $urandom, rw);
    end

    // Asynchronous reset mid-cycle with an update pending
    wr(5'd12, 32'h0000_00FF);
    wr(5'd14, 32'h0000_ABCD);
    bus.mtc0 = 1; bus.cp0_addr = 5'd12; bus.wdata = 32'h1111_1111; bus.mfc0 = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_status", bus.status, 32'h0);
    chk("mid_epc", bus.epc_out, 32'h0);
    chk("mid_irq", {31'h0, bus.irq}, 32'h0);
    bus.mtc0 = 0; bus.mfc0 = 1;
    for (int k = 0; k < 5; k++) begin
      bus.cp0_addr = addrs[k];
      #1;
      chk("mid_reg", bus.rdata, 32'h0);
    end
    bus.mfc0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'd9); chk("post_rst_count0", last_rd, 32'h0);
    rd(5'd9); chk("post_rst_count1", last_rd, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; ports clk and rst_n.
REQ-002 Ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- stall  in  1  pipeline stall; freezes all architectural updates except Count
- mfc0  in  1  move-from-CP0 strobe
- mtc0  in  1  move-to-CP0 strobe
- eret  in  1  exception-return strobe
- exception  in  1  take exception this cycle (already masked by Status)
- cp0_addr  in  5  CP0 register index
- cause  in  5  ExcCode of the exception being taken
- pc  in  32  address of the excepting instruction
- wdata  in  32  mtc0 source data (rt)
- rdata  out  32  mfc0 read data
- status  out  32  current Status register
- epc_out  out  32  current EPC register
- exc_addr  out  32  redirect target for the PC mux
- irq  out  1  timer interrupt request

Function
REQ-003 The block SHALL implement these registers: Count (9), Compare (11), Status (12), Cause (13), EPC (14).
REQ-004 rdata SHALL be combinational: the addressed register when mfc0=1, else 0; an unmapped index SHALL read 0.
REQ-005 exc_addr SHALL equal EPC when eret=1, else the constant EXC_VECTOR = 0x0000_0004.
REQ-006 Count SHALL increment by 1 every cycle, independent of stall, and wrap from 0xFFFF_FFFF to 0.
REQ-007 On exception=1 and stall=0, the next edge SHALL set:
- Status <= Status << 5
- Cause[6:2] <= cause
- EPC <= pc
REQ-008 On eret=1 and stall=0, the next edge SHALL set Status <= Status >> 5 (logical); EPC SHALL be unchanged.
REQ-009 On mtc0=1 and stall=0, the next edge SHALL write wdata to the register at cp0_addr, with these rules:
- Cause: only bits [6:2] are written.
- Compare: the write also clears Cause[15].
- Unmapped index: the write is ignored.
REQ-010 Priority within a cycle SHALL be exception > eret > mtc0; only the highest-priority action updates Status, Cause and EPC.
REQ-011 An mtc0 to Count SHALL override the increment that cycle.
REQ-012 When Count equals Compare and Compare is nonzero, Cause[15] SHALL be set at the next edge. It stays set until a Compare write or reset, and is set regardless of stall.
REQ-013 irq SHALL equal Status[0] & Status[4] & Cause[15].
REQ-014 Status bits [3:0] SHALL keep the decoder's meanings: interrupt enable, syscall, break and teq masks. Bit 4 SHALL be the timer enable.
REQ-015 status and epc_out SHALL be direct register outputs with no combinational bypass, so a value written this cycle is visible next cycle.
REQ-016 Simultaneous mfc0 and mtc0 to the same index SHALL return the old value.

Reset
REQ-017 On rst_n low, all five registers SHALL clear to 0 immediately.
REQ-018 Out of reset, rdata, status, epc_out and irq SHALL be 0, and exc_addr SHALL be 0x0000_0004.
REQ-019 Reset asserted mid-operation SHALL discard any pending update; the first post-reset edge SHALL advance Count to 1.

Structure
REQ-020 A shared package SHALL hold:
- register index constants: CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14
- EXC_VECTOR
- ExcCode constants: SYSCALL=8, BREAK=9, TEQ=13, INT=0
- STATUS_SHIFT=5
REQ-021 One sub-module SHALL be used: cp0_timer, containing Count, the compare match logic and Cause[15] generation.

Verification
REQ-022 Syscall entry: mtc0 Status=0x0000000F, then exception=1, cause=8, pc=0x0040_0010. Next cycle: Status=0x000001E0, Cause[6:2]=8, EPC=0x0040_0010, exc_addr=4.
REQ-023 Eret: after REQ-022, eret=1. exc_addr=0x0040_0010 in the same cycle; Status=0x0000000F next cycle.
REQ-024 Timer: mtc0 Compare=20 and Status=0x11. Cause[15]=1 and irq=1 one edge after Count reaches 20. A Compare write then clears irq.
REQ-025 Stall: stall=1 with exception=1 and mtc0=1. Status, Cause and EPC are unchanged; Count still increments.
REQ-026 Collision and reset: exception and mtc0 Status=0xFFFF in the same cycle. Only the exception effects apply. Asserting rst_n=0 mid-cycle zeroes all registers at once.
